// File: rtl/imem_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the synchronous instruction memory: fault codes,
// fetch FSM state encoding, the NOP word and a constant clog2 helper.
package imem_pkg;

    localparam logic [1:0] FAULT_OK       = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_sync_if.sv
`timescale 1ns/1ps
// Fetch request/response channel between the IF stage (master) and the
// instruction memory (slave).
interface imem_sync_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_fault;

    modport master (
        output req_valid, req_addr, flush,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, flush,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/imem_array.sv
`timescale 1ns/1ps
// Instruction word storage: one synchronous write port, one combinational
// read port. Kept apart from the fetch FSM so a RAM macro can replace it.
module imem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents survive reset; the program is (re)loaded through the write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];
endmodule

// File: rtl/imem_sync.sv
`timescale 1ns/1ps
// Clocked instruction memory with fetch handshake, programmable read latency
// and fault detection. Define IMEM_PREFETCH_EN to add a one-entry next-word buffer.
module imem_sync
    import imem_pkg::*;
#(
    parameter  int ADDR_W = 64,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    parameter  int RD_LAT = 2,
    localparam int IDX_W  = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    imem_sync_if.slave        fetch,
    input  logic              i_ld_en,
    input  logic [IDX_W-1:0]  i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_busy
);
    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_hold_data;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_fault;
    logic              r_rsp_valid;

    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_pf_data;
    logic [DATA_W-1:0] w_fetch_data;
    logic              w_misalign;
    logic              w_range;
    logic [1:0]        w_fault;
    logic              w_ready;
    logic              w_accept;
    logic              w_pf_hit;
    logic              w_fast;

    assign w_req_idx  = fetch.req_addr[IDX_W+1:2];
    assign w_misalign = |fetch.req_addr[1:0];
    assign w_range    = |fetch.req_addr[ADDR_W-1:IDX_W+2];
    assign w_fault    = w_misalign ? FAULT_MISALIGN : (w_range ? FAULT_RANGE : FAULT_OK);

    assign w_ready  = (r_state != WAIT);
    assign w_accept = fetch.req_valid && w_ready && !fetch.flush;

    // Faults and buffer hits bypass the wait states and answer next cycle.
    assign w_fast       = (RD_LAT == 1) || (w_fault != FAULT_OK) || w_pf_hit;
    assign w_fetch_data = (w_fault != FAULT_OK) ? DATA_W'(NOP_WORD)
                        : (w_pf_hit ? w_pf_data : w_rd_data);

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk     (i_clk),
        .i_wr_en   (i_ld_en),
        .i_wr_idx  (i_ld_addr),
        .i_wr_data (i_ld_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

`ifdef IMEM_PREFETCH_EN
    logic              r_pf_valid;
    logic [IDX_W-1:0]  r_pf_idx;
    logic [DATA_W-1:0] r_pf_data;
    logic [IDX_W-1:0]  r_nxt_idx;
    logic              r_nxt_ok;
    logic              w_pf_load;

    assign w_pf_hit  = r_pf_valid && (w_fault == FAULT_OK) && (w_req_idx == r_pf_idx);
    assign w_pf_data = r_pf_data;
    // The read port is free during a RESP cycle that accepts nothing.
    assign w_pf_load = (r_state == RESP) && r_nxt_ok && !w_accept && !fetch.flush;
    assign w_rd_idx  = w_pf_load ? r_nxt_idx : w_req_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pf_valid <= 1'b0;
            r_pf_idx   <= '0;
            r_pf_data  <= '0;
            r_nxt_idx  <= '0;
            r_nxt_ok   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nxt_idx <= w_req_idx + IDX_W'(1);
                r_nxt_ok  <= (w_fault == FAULT_OK) && (w_req_idx != IDX_W'(DEPTH - 1));
            end
            if (fetch.flush || (w_accept && (w_fault != FAULT_OK))) begin
                r_pf_valid <= 1'b0;
            end else if (w_pf_load) begin
                r_pf_valid <= !(i_ld_en && (i_ld_addr == r_nxt_idx));
                r_pf_idx   <= r_nxt_idx;
                r_pf_data  <= w_rd_data;
            end else if (i_ld_en && (i_ld_addr == r_pf_idx)) begin
                r_pf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_pf_hit  = 1'b0;
    assign w_pf_data = '0;
    assign w_rd_idx  = w_req_idx;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_data <= '0;
            r_rsp_data  <= '0;
            r_rsp_fault <= FAULT_OK;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        if (w_fast) begin
                            r_state     <= RESP;
                            r_rsp_data  <= w_fetch_data;
                            r_rsp_fault <= w_fault;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            // Word is captured now, so later loads cannot alter it.
                            r_state     <= WAIT;
                            r_cnt       <= LAT_M1;
                            r_hold_data <= w_fetch_data;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (fetch.flush) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_rsp_data  <= r_hold_data;
                        r_rsp_fault <= FAULT_OK;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fetch.req_ready = w_ready;
    assign fetch.rsp_valid = r_rsp_valid;
    assign fetch.rsp_data  = r_rsp_data;
    assign fetch.rsp_fault = r_rsp_fault;
    assign o_busy          = (r_state != IDLE);
endmodule

// File: tb/tb_imem_sync.sv
`timescale 1ns/1ps
// Randomised bench for imem_sync against a cycle-indexed transaction model:
// each accepted fetch is expected to surface a fixed number of edges later.
module tb_imem_sync;
    import imem_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;
    localparam int IDX_W  = clog2(DEPTH);
`ifdef IMEM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic              ld_en   = 1'b0;
    logic [IDX_W-1:0]  ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              busy;

    imem_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .fetch     (bus),
        .i_ld_en   (ld_en),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data),
        .o_busy    (busy)
    );

    // Reference state: memory image, one outstanding fetch, last response, buffer.
    logic [31:0] mem [DEPTH];
    int          cyc = 0;
    bit          pend = 0;
    int          pend_edge = 0;
    logic [31:0] pend_data = '0;
    logic [1:0]  pend_fault = '0;
    bit          pend_cand_ok = 0;
    int          pend_cand_idx = 0;
    bit          cur_cand_ok = 0;
    int          cur_cand_idx = 0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_fault = '0;
    bit          pf_valid = 0;
    int          pf_idx = 0;
    logic [31:0] pf_data = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Called just after a falling edge: check outputs, drive the next edge, advance.
    task automatic cycle(input bit v, input logic [63:0] a, input bit fl,
                         input bit le, input int la, input logic [31:0] ld, output bit acc);
        bit          exp_valid, exp_ready, exp_busy, do_pf;
        logic [1:0]  f;
        logic [31:0] d;
        int          idx, lat;
        exp_valid = pend && (cyc == pend_edge);
        exp_busy  = pend && (cyc <= pend_edge);
        exp_ready = !(pend && (cyc < pend_edge));
        if (exp_valid) begin
            last_data    = pend_data;
            last_fault   = pend_fault;
            cur_cand_ok  = pend_cand_ok;
            cur_cand_idx = pend_cand_idx;
        end
        check("rsp_valid", bus.rsp_valid, exp_valid);
        check("req_ready", bus.req_ready, exp_ready);
        check("busy", busy, exp_busy);
        check("rsp_data", bus.rsp_data, last_data);
        check("rsp_fault", bus.rsp_fault, last_fault);
        if (exp_valid) $display("rsp cyc=%0d data=%08h fault=%0d", cyc, last_data, last_fault);
        if (pend && cyc >= pend_edge) pend = 0;

        bus.req_valid = v;
        bus.req_addr  = a;
        bus.flush     = fl;
        ld_en         = le;
        ld_addr       = IDX_W'(la);
        ld_data       = ld;
        acc = v && exp_ready && !fl;
        if (fl) pend = 0;
        do_pf = PF && exp_valid && cur_cand_ok && !acc && !fl;

        f = FAULT_OK;
        if (acc) begin
            idx = int'(a[IDX_W+1:2]);
            if (a[1:0] != 2'b00)       f = FAULT_MISALIGN;
            else if (a >= DEPTH * 4)   f = FAULT_RANGE;
            if (f != FAULT_OK) begin
                d = 32'h0; lat = 1;
            end else if (PF && pf_valid && idx == pf_idx) begin
                d = pf_data; lat = 1;
            end else begin
                d = mem[idx]; lat = RD_LAT;
            end
            pend          = 1;
            pend_edge     = cyc + lat;
            pend_data     = d;
            pend_fault    = f;
            pend_cand_ok  = (f == FAULT_OK) && (idx + 1 < DEPTH);
            pend_cand_idx = idx + 1;
        end
        if (fl || (acc && f != FAULT_OK)) begin
            pf_valid = 0;
        end else if (do_pf) begin
            pf_valid = 1; pf_idx = cur_cand_idx; pf_data = mem[cur_cand_idx];
        end
        if (le && pf_valid && la == pf_idx) pf_valid = 0;
        if (le) mem[la] = ld;

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, acc);
    endtask

    // Presents queued addresses with req_valid held until each is accepted.
    task automatic stream();
        bit acc;
        int guard;
        guard = 0;
        while ((q.size() > 0 || pend) && guard < 60) begin
            cycle(q.size() > 0, (q.size() > 0) ? q[0] : 64'h0, 0, 0, 0, '0, acc);
            if (acc) void'(q.pop_front());
            guard++;
        end
        check("stream_drained", 64'(q.size()), 64'h0);
        q.delete();
    endtask

    // Asynchronous reset from mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        ld_en         = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_rsp_fault", bus.rsp_fault, 2'd0);
        pend = 0; last_data = '0; last_fault = '0; pf_valid = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          r;
        logic [63:0] a, prev_a;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        prev_a        = '0;
        @(negedge clk);
        do_reset();

        // Program load: word 0 fixed, the rest random.
        for (int i = 0; i < DEPTH; i++)
            cycle(0, '0, 0, 1, i, (i == 0) ? 32'hD2800140 : $urandom, acc);

        cycle(1, 64'h000, 0, 0, 0, '0, acc);
        idle(3);
        q = '{64'h000, 64'h004, 64'h008};
        stream();
        q = '{64'h006, 64'h400, 64'h3FC, 64'h3FE};
        stream();

        // Flush while waiting, then a normal fetch.
        cycle(1, 64'h010, 0, 0, 0, '0, acc);
        cycle(0, '0, 1, 0, 0, '0, acc);
        idle(3);
        q = '{64'h014};
        stream();

        // Same-edge load to the word being fetched returns the old word.
        cycle(1, 64'h010, 0, 1, 4, 32'hCAFEF00D, acc);
        idle(2);
        q = '{64'h010};
        stream();

        cycle(1, 64'h020, 0, 0, 0, '0, acc);
        do_reset();
        idle(4);

        q = '{64'h000};
        stream();
        idle(1);
        q = '{64'h004};
        stream();

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = {$urandom, $urandom} | 64'h1;
            else if (r == 1) a = 64'(DEPTH * 4) + 64'($urandom_range(0, 63)) * 4;
            else if (r < 6)  a = 64'(((int'(prev_a[IDX_W+1:2]) + 1) % DEPTH) * 4);
            else             a = 64'($urandom_range(0, DEPTH - 1)) * 4;
            cycle($urandom_range(0, 2) != 0, a, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, DEPTH - 1)), $urandom, acc);
            if (acc) prev_a = a;
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
